// File: rtl/decode_queue.sv
// Decoding instruction queue: classifies each fetched MIPS32 word at push and tracks delay slots.
// Latency 1 into an empty queue; in_ready drops when full, with no push-through even on a same-cycle pop.
module decode_queue #(
    parameter int QDEPTH = 4,
    parameter bit EXT_EN = 1'b0,
    parameter int PC_W   = 32
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic                        flush,
    input  logic                        in_valid,
    output logic                        in_ready,
    input  logic [31:0]                 in_inst,
    input  logic [PC_W-1:0]             in_pc,
    output logic                        out_valid,
    input  logic                        out_ready,
    output logic [31:0]                 out_inst,
    output logic [PC_W-1:0]             out_pc,
    output logic [9:0]                  out_bj,
    output logic                        out_load,
    output logic                        out_store,
    output logic                        out_ext,
    output logic                        out_invalid,
    output logic                        out_in_ds,
    output logic [$clog2(QDEPTH+1)-1:0] count
);
    localparam int PTR_W = $clog2(QDEPTH);
    localparam int CNT_W = $clog2(QDEPTH + 1);

    typedef struct packed {
        logic [31:0]     inst;
        logic [PC_W-1:0] pc;
        logic [9:0]      bj;
        logic            load;
        logic            store;
        logic            ext;
        logic            invalid;
        logic            in_ds;
    } entry_t;

    entry_t           mem [QDEPTH];
    entry_t           in_entry;
    entry_t           head;
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [CNT_W-1:0] count_q;
    logic             ds_next;
    logic             push;
    logic             pop;

    logic [5:0] op;
    logic [5:0] funct;
    logic [4:0] rs;
    logic [4:0] rt;
    logic [9:0] bj;
    logic       is_load;
    logic       is_store;
    logic       base_ok;
    logic       ext_hit;
    logic       recognised;

    assign op    = in_inst[31:26];
    assign rs    = in_inst[25:21];
    assign rt    = in_inst[20:16];
    assign funct = in_inst[5:0];

    always_comb begin
        bj       = '0;
        is_load  = 1'b0;
        is_store = 1'b0;
        base_ok  = 1'b0;
        ext_hit  = 1'b0;
        case (op)
            6'h00: begin
                case (funct)
                    6'h00, 6'h02, 6'h03, 6'h04, 6'h06, 6'h07, 6'h0C, 6'h0D,
                    6'h10, 6'h11, 6'h12, 6'h13, 6'h18, 6'h19, 6'h1A, 6'h1B,
                    6'h20, 6'h21, 6'h22, 6'h23, 6'h24, 6'h25, 6'h26, 6'h27,
                    6'h2A, 6'h2B:  base_ok = 1'b1;
                    6'h08, 6'h09:  bj[9]   = 1'b1;
                    6'h0A, 6'h0B:  ext_hit = 1'b1;
                    default: ;
                endcase
            end
            6'h01: begin
                case (rt)
                    5'h00:   bj[5] = 1'b1;
                    5'h01:   bj[2] = 1'b1;
                    5'h10:   bj[6] = 1'b1;
                    5'h11:   bj[7] = 1'b1;
                    default: ;
                endcase
            end
            6'h02, 6'h03: bj[8] = 1'b1;
            6'h04:        bj[0] = 1'b1;
            6'h05:        bj[1] = 1'b1;
            6'h06:        bj[4] = 1'b1;
            6'h07:        bj[3] = 1'b1;
            6'h08, 6'h09, 6'h0A, 6'h0B, 6'h0C, 6'h0D, 6'h0E, 6'h0F: base_ok = 1'b1;
            // COP0: eret, mfc0 (rs=0), mtc0 (rs=4)
            6'h10: base_ok = (in_inst == 32'h4200_0018) || (rs == 5'h00) || (rs == 5'h04);
            6'h1C: ext_hit = (funct == 6'h20) || (funct == 6'h21) || (funct == 6'h02);
            6'h20, 6'h21, 6'h23, 6'h24, 6'h25: is_load  = 1'b1;
            6'h28, 6'h29, 6'h2B:               is_store = 1'b1;
            default: ;
        endcase
    end

    assign recognised = base_ok || (|bj) || is_load || is_store || (EXT_EN && ext_hit);

    always_comb begin
        in_entry         = '0;
        in_entry.inst    = in_inst;
        in_entry.pc      = in_pc;
        in_entry.bj      = bj;
        in_entry.load    = is_load;
        in_entry.store   = is_store;
        in_entry.ext     = EXT_EN && ext_hit;
        in_entry.invalid = ~recognised;
        in_entry.in_ds   = ds_next;
    end

    assign in_ready  = (count_q < CNT_W'(QDEPTH));
    assign out_valid = (count_q != '0);
    assign push      = in_valid && in_ready && !flush;
    assign pop       = out_valid && out_ready && !flush;

    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= in_entry;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            count_q <= '0;
            ds_next <= 1'b0;
        end else if (flush) begin
            rd_ptr  <= wr_ptr;
            count_q <= '0;
            ds_next <= 1'b0;
        end else begin
            if (push) begin
                wr_ptr  <= wr_ptr + 1'b1;
                ds_next <= |bj;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({push, pop})
                2'b10:   count_q <= count_q + 1'b1;
                2'b01:   count_q <= count_q - 1'b1;
                default: ;
            endcase
        end
    end

    assign head        = mem[rd_ptr];
    assign out_inst    = head.inst;
    assign out_pc      = head.pc;
    assign out_bj      = head.bj;
    assign out_load    = head.load;
    assign out_store   = head.store;
    assign out_ext     = head.ext;
    assign out_invalid = head.invalid;
    assign out_in_ds   = head.in_ds;
    assign count       = count_q;
endmodule

// File: tb/tb_decode_queue.sv
// Bench for decode_queue: two instances (EXT_EN=0/1) share stimulus; a scoreboard of table indices
// supplies the expected head fields at each pop.
module tb_decode_queue;
    localparam int QD   = 4;
    localparam int PC_W = 32;
    localparam int CW   = $clog2(QD + 1);

    logic            clk;
    logic            rst_n;
    logic            flush;
    logic            in_valid;
    logic [31:0]     in_inst;
    logic [PC_W-1:0] in_pc;
    logic            out_ready;

    logic            o0_in_ready, o0_valid, o0_load, o0_store, o0_ext, o0_invalid, o0_in_ds;
    logic [31:0]     o0_inst;
    logic [PC_W-1:0] o0_pc;
    logic [9:0]      o0_bj;
    logic [CW-1:0]   o0_count;
    logic            o1_in_ready, o1_valid, o1_load, o1_store, o1_ext, o1_invalid, o1_in_ds;
    logic [31:0]     o1_inst;
    logic [PC_W-1:0] o1_pc;
    logic [9:0]      o1_bj;
    logic [CW-1:0]   o1_count;

    decode_queue #(.QDEPTH(QD), .EXT_EN(1'b0), .PC_W(PC_W)) dut0 (
        .clk(clk), .rst_n(rst_n), .flush(flush),
        .in_valid(in_valid), .in_ready(o0_in_ready), .in_inst(in_inst), .in_pc(in_pc),
        .out_valid(o0_valid), .out_ready(out_ready), .out_inst(o0_inst), .out_pc(o0_pc),
        .out_bj(o0_bj), .out_load(o0_load), .out_store(o0_store), .out_ext(o0_ext),
        .out_invalid(o0_invalid), .out_in_ds(o0_in_ds), .count(o0_count)
    );

    decode_queue #(.QDEPTH(QD), .EXT_EN(1'b1), .PC_W(PC_W)) dut1 (
        .clk(clk), .rst_n(rst_n), .flush(flush),
        .in_valid(in_valid), .in_ready(o1_in_ready), .in_inst(in_inst), .in_pc(in_pc),
        .out_valid(o1_valid), .out_ready(out_ready), .out_inst(o1_inst), .out_pc(o1_pc),
        .out_bj(o1_bj), .out_load(o1_load), .out_store(o1_store), .out_ext(o1_ext),
        .out_invalid(o1_invalid), .out_in_ds(o1_in_ds), .count(o1_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] inst;
        logic [9:0]  bj;
        logic        ld;
        logic        st;
        logic        x0;
        logic        inv0;
        logic        x1;
        logic        inv1;
    } vec_t;

    typedef struct {
        int          idx;
        logic [31:0] pc;
        logic        ds;
    } sb_t;

    localparam int NV    = 28;
    localparam int I_ADD = 0;
    localparam int I_JAL = 9;

    vec_t tab [NV];
    sb_t  sb [$];
    int   cur;
    logic ds_model;
    int   errors = 0;
    int   checks = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic offer(input int idx, input logic [31:0] pc);
        cur      = idx;
        in_valid = 1'b1;
        in_inst  = tab[idx].inst;
        in_pc    = pc;
    endtask

    // Bookkeeping for the coming edge, then advance to 1 time unit past it.
    task automatic tick();
        sb_t e;
        bit  acc;
        bit  pp;
        chk("in_ready0", o0_in_ready, sb.size() < QD);
        chk("in_ready1", o1_in_ready, sb.size() < QD);
        chk("out_valid0", o0_valid, sb.size() != 0);
        acc = in_valid && (sb.size() < QD) && !flush;
        pp  = out_ready && (sb.size() != 0) && !flush;
        if (pp) begin
            e = sb.pop_front();
            chk("inst", o0_inst, tab[e.idx].inst);
            chk("pc", o0_pc, e.pc);
            chk("bj0", o0_bj, tab[e.idx].bj);
            chk("load", o0_load, tab[e.idx].ld);
            chk("store", o0_store, tab[e.idx].st);
            chk("ext0", o0_ext, tab[e.idx].x0);
            chk("invalid0", o0_invalid, tab[e.idx].inv0);
            chk("in_ds0", o0_in_ds, e.ds);
            chk("bj1", o1_bj, tab[e.idx].inv1 ? 10'h0 : tab[e.idx].bj);
            chk("ext1", o1_ext, tab[e.idx].x1);
            chk("invalid1", o1_invalid, tab[e.idx].inv1);
            chk("in_ds1", o1_in_ds, e.ds);
        end
        if (flush) begin
            sb.delete();
            ds_model = 1'b0;
        end else if (acc) begin
            sb.push_back('{idx: cur, pc: in_pc, ds: ds_model});
            ds_model = (tab[cur].bj != 10'h0);
        end
        @(posedge clk);
        #1;
        chk("count0", o0_count, sb.size());
        chk("count1", o1_count, sb.size());
    endtask

    initial begin
        //            inst          bj      ld    st    x0    inv0  x1    inv1
        tab[0]  = '{32'h0043_0821, 10'h000, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0}; // addu
        tab[1]  = '{32'h1000_FFFF, 10'h001, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0}; // beq
        tab[2]  = '{32'h8C22_0004, 10'h000, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0}; // lw
        tab[3]  = '{32'hAC22_0008, 10'h000, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0}; // sw
        tab[4]  = '{32'hFC00_0000, 10'h000, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1}; // undefined op
        tab[5]  = '{32'h7000_0020, 10'h000, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0}; // clz
        tab[6]  = '{32'h7022_1002, 10'h000, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0}; // mul
        tab[7]  = '{32'h0022_180B, 10'h000, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0}; // movn
        tab[8]  = '{32'h03E0_0008, 10'h200, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0}; // jr
        tab[9]  = '{32'h0C00_0040, 10'h100, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0}; // jal
        tab[10] = '{32'h0410_0010, 10'h040, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0}; // bltzal
        tab[11] = '{32'h0401_0004, 10'h004, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0}; // bgez
        tab[12] = '{32'h4200_0018, 10'h000, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0}; // eret
        tab[13] = '{32'h4002_6000, 10'h000, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0}; // mfc0
        tab[14] = '{32'h0000_000C, 10'h000, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0}; // syscall
        tab[15] = '{32'h9022_0000, 10'h000, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0}; // lbu
        tab[16] = '{32'hA422_0000, 10'h000, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0}; // sh
        tab[17] = '{32'h1C20_0003, 10'h008, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0}; // bgtz
        tab[18] = '{32'h1820_0003, 10'h010, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0}; // blez
        tab[19] = '{32'h1422_0001, 10'h002, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0}; // bne
        tab[20] = '{32'h0800_0010, 10'h100, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0}; // j
        tab[21] = '{32'h0411_0002, 10'h080, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0}; // bgezal
        tab[22] = '{32'h0400_0002, 10'h020, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0}; // bltz
        tab[23] = '{32'h0040_0009, 10'h200, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0}; // jalr
        tab[24] = '{32'h0000_003F, 10'h000, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1}; // bad funct
        tab[25] = '{32'h0402_0000, 10'h000, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1}; // bad regimm
        tab[26] = '{32'h4084_6000, 10'h000, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0}; // mtc0
        tab[27] = '{32'h0000_0000, 10'h000, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0}; // sll nop

        rst_n     = 1'b0;
        flush     = 1'b0;
        in_valid  = 1'b0;
        in_inst   = '0;
        in_pc     = '0;
        out_ready = 1'b0;
        cur       = 0;
        ds_model  = 1'b0;
        #3;
        chk("rst_out_valid", o0_valid, 1'b0);
        chk("rst_in_ready", o0_in_ready, 1'b1);
        chk("rst_count", o0_count, 0);
        #5 rst_n = 1'b1;
        @(posedge clk);
        #1;

        // Each vector through an empty queue: push, then pop on the following cycle.
        out_ready = 1'b1;
        for (int i = 0; i < NV; i++) begin
            offer(i, 32'h100 + 32'(i * 4));
            tick();
            in_valid = 1'b0;
            tick();
        end

        // Fill to capacity with a held 5th word, then release one slot.
        out_ready = 1'b0;
        for (int k = 0; k < 4; k++) begin
            offer(k, 32'h200 + 32'(k * 4));
            tick();
        end
        offer(4, 32'h210);
        tick();
        chk("full_held_ready", o0_in_ready, 1'b0);
        out_ready = 1'b1;
        tick();
        tick();
        in_valid = 1'b0;
        for (int k = 0; k < 4; k++) tick();
        chk("drained_valid", o0_valid, 1'b0);

        // Flush with a trailing jal and a concurrent push.
        out_ready = 1'b0;
        offer(I_ADD, 32'h300); tick();
        offer(I_ADD, 32'h304); tick();
        offer(I_JAL, 32'h308); tick();
        flush = 1'b1;
        offer(I_ADD, 32'h30C);
        tick();
        flush    = 1'b0;
        in_valid = 1'b0;
        chk("flush_valid", o0_valid, 1'b0);
        tick();
        out_ready = 1'b1;
        offer(I_ADD, 32'h310); tick();
        in_valid = 1'b0;
        tick();

        // Async reset mid-cycle with two entries and a pending delay slot.
        out_ready = 1'b0;
        offer(I_ADD, 32'h400); tick();
        offer(I_JAL, 32'h404); tick();
        in_valid = 1'b0;
        #2 rst_n = 1'b0;
        #1;
        chk("arst_valid0", o0_valid, 1'b0);
        chk("arst_count0", o0_count, 0);
        chk("arst_ready0", o0_in_ready, 1'b1);
        chk("arst_valid1", o1_valid, 1'b0);
        sb.delete();
        ds_model = 1'b0;
        #1 rst_n = 1'b1;
        tick();
        out_ready = 1'b1;
        offer(I_ADD, 32'h408); tick();
        in_valid = 1'b0;
        tick();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
